// File: rtl/pulso_timer_if.sv
// rtl/pulso_timer_if.sv - control and status bundle for the pulso_timer
interface pulso_timer_if #(
  parameter int WIDTH = 18
);
  logic             OP;
  logic             En;
  logic [WIDTH-1:0] Period;
  logic [1:0]       Mode;
  logic             Mo;
  logic             Pulse;
  logic             Busy;
  logic [WIDTH-1:0] Count;

  modport master (
    output OP, En, Period, Mode,
    input  Mo, Pulse, Busy, Count
  );

  modport slave (
    input  OP, En, Period, Mode,
    output Mo, Pulse, Busy, Count
  );
endinterface

// File: rtl/pulso_timer.sv
// rtl/pulso_timer.sv - synchronous pulse delay timer with one-shot and periodic modes
module pulso_timer #(
  parameter int WIDTH    = 18,
  parameter int DEF_MODE = 0
) (
  input  logic         Clk,
  input  logic         Rst_n,
  pulso_timer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] preg_q, preg_d;
  logic [1:0]       mreg_q, mreg_d;
  logic             mo_q, mo_d;
  logic             pulse_q, pulse_d;
  logic             busy_q;
  logic [WIDTH-1:0] period_eff;
  logic             terminal;

  // DEF_MODE only documents the integration tie-off; Mode is two bits wide,
  // so anything outside 0..3 could never be tied to the port.
  if (DEF_MODE < 0 || DEF_MODE > 3) begin : g_def_mode_out_of_range
  end

  // A zero terminal count would never be reached, so it is promoted to one.
  assign period_eff = (bus.Period == '0) ? WIDTH'(1) : bus.Period;
  assign terminal   = bus.En && (count_q == preg_q - WIDTH'(1));

  // Next-state and output decode; OP high always wins over a terminal edge.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    preg_d  = preg_q;
    mreg_d  = mreg_q;
    mo_d    = mo_q;
    pulse_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.OP) begin
          state_d = ARM;
          count_d = '0;
          mo_d    = 1'b0;
        end
      end
      ARM: begin
        count_d = '0;
        mo_d    = 1'b0;
        if (!bus.OP) begin
          state_d = RUN;
          preg_d  = period_eff;
          mreg_d  = bus.Mode;
        end
      end
      RUN: begin
        if (bus.OP) begin
          state_d = ARM;
          count_d = '0;
          mo_d    = 1'b0;
        end else if (terminal) begin
          pulse_d = 1'b1;
          unique case (mreg_q)
            2'd1: begin
              state_d = IDLE;
              count_d = '0;
            end
            2'd2: begin
              count_d = '0;
              preg_d  = period_eff;
            end
            default: begin
              state_d = DONE;
              count_d = preg_q;
              mo_d    = 1'b1;
            end
          endcase
        end else if (bus.En) begin
          count_d = count_q + WIDTH'(1);
        end
      end
      DONE: begin
        if (bus.OP) begin
          state_d = ARM;
          count_d = '0;
          mo_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset overrides everything, including mid-count.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      preg_q  <= '0;
      mreg_q  <= 2'd0;
      mo_q    <= 1'b0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      preg_q  <= preg_d;
      mreg_q  <= mreg_d;
      mo_q    <= mo_d;
      pulse_q <= pulse_d;
      busy_q  <= (state_d == RUN);
    end
  end

  assign bus.Count = count_q;
  assign bus.Mo    = mo_q;
  assign bus.Pulse = pulse_q;
  assign bus.Busy  = busy_q;

endmodule

// File: tb/tb_pulso_timer.sv
// tb/tb_pulso_timer.sv - directed self-checking bench for pulso_timer
module tb_pulso_timer;

  logic Clk = 1'b0;
  logic Rst_n;
  int   n_cmp  = 0;
  int   n_fail = 0;

  pulso_timer_if #(.WIDTH(18)) a ();
  pulso_timer_if #(.WIDTH(4))  b ();

  pulso_timer #(.WIDTH(18), .DEF_MODE(0)) u_a (.Clk(Clk), .Rst_n(Rst_n), .bus(a.slave));
  pulso_timer #(.WIDTH(4),  .DEF_MODE(0)) u_b (.Clk(Clk), .Rst_n(Rst_n), .bus(b.slave));

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic busy, input logic pulse,
                       input logic mo, input logic [17:0] cnt);
    logic [20:0] obs;
    logic [20:0] exp;
    obs = {a.Busy, a.Pulse, a.Mo, a.Count};
    exp = {busy, pulse, mo, cnt};
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: busy/pulse/mo/count observed %b/%b/%b/%0d expected %b/%b/%b/%0d",
             tag, obs[20], obs[19], obs[18], obs[17:0], busy, pulse, mo, cnt);
    end
  endtask

  task automatic chk_b(input string tag, input logic busy, input logic pulse,
                       input logic mo, input logic [3:0] cnt);
    logic [6:0] obs;
    logic [6:0] exp;
    obs = {b.Busy, b.Pulse, b.Mo, b.Count};
    exp = {busy, pulse, mo, cnt};
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: busy/pulse/mo/count observed %b/%b/%b/%0d expected %b/%b/%b/%0d",
             tag, obs[6], obs[5], obs[4], obs[3:0], busy, pulse, mo, cnt);
    end
  endtask

  initial begin
    Rst_n = 1'b0;
    a.OP = 1'b0; a.En = 1'b1; a.Period = '0; a.Mode = 2'd0;
    b.OP = 1'b0; b.En = 1'b1; b.Period = '0; b.Mode = 2'd0;
    tick();
    tick();
    chk_a("reset_a", 0, 0, 0, 0);
    chk_b("reset_b", 0, 0, 0, 0);

    // Reset release with OP already low must not start anything.
    Rst_n = 1'b1;
    tick();
    chk_a("release_idle0", 0, 0, 0, 0);
    tick();
    chk_a("release_idle1", 0, 0, 0, 0);

    // Latched one-shot, Period=5.
    a.Period = 18'd5; a.Mode = 2'd0; a.OP = 1'b1;
    tick();
    chk_a("m0_arm", 0, 0, 0, 0);
    a.OP = 1'b0;
    tick();
    chk_a("m0_start", 1, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk_a("m0_count", 1, 0, 0, 18'(i));
    end
    tick();
    chk_a("m0_expire", 0, 1, 1, 5);
    tick();
    chk_a("m0_done_hold", 0, 0, 1, 5);

    // Periodic, Period=3, then 2 mid-run; Mode change must be ignored.
    a.OP = 1'b1;
    tick();
    chk_a("m2_arm", 0, 0, 0, 0);
    a.Period = 18'd3; a.Mode = 2'd2; a.OP = 1'b0;
    tick();
    chk_a("m2_start", 1, 0, 0, 0);
    tick(); chk_a("m2_c1", 1, 0, 0, 1);
    tick(); chk_a("m2_c2", 1, 0, 0, 2);
    tick(); chk_a("m2_p1", 1, 1, 0, 0);
    a.Period = 18'd2; a.Mode = 2'd0;
    tick(); chk_a("m2_c1b", 1, 0, 0, 1);
    tick(); chk_a("m2_c2b", 1, 0, 0, 2);
    tick(); chk_a("m2_p2", 1, 1, 0, 0);
    tick(); chk_a("m2_c1c", 1, 0, 0, 1);
    tick(); chk_a("m2_p3", 1, 1, 0, 0);
    tick(); chk_a("m2_c1d", 1, 0, 0, 1);
    tick(); chk_a("m2_p4", 1, 1, 0, 0);

    // Single-cycle one-shot, Period=4.
    a.OP = 1'b1;
    tick();
    chk_a("m1_arm", 0, 0, 0, 0);
    a.Period = 18'd4; a.Mode = 2'd1; a.OP = 1'b0;
    tick();
    chk_a("m1_start", 1, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_a("m1_count", 1, 0, 0, 18'(i));
    end
    tick();
    chk_a("m1_pulse", 0, 1, 0, 0);
    tick();
    chk_a("m1_idle0", 0, 0, 0, 0);
    tick();
    chk_a("m1_idle1", 0, 0, 0, 0);

    // Enable stall: Period=6, frozen at Count=2 for three edges.
    a.OP = 1'b1;
    tick();
    chk_a("en_arm", 0, 0, 0, 0);
    a.Period = 18'd6; a.Mode = 2'd0; a.OP = 1'b0;
    tick();
    chk_a("en_start", 1, 0, 0, 0);
    tick(); chk_a("en_c1", 1, 0, 0, 1);
    tick(); chk_a("en_c2", 1, 0, 0, 2);
    a.En = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_a("en_frozen", 1, 0, 0, 2);
    end
    a.En = 1'b1;
    for (int i = 3; i <= 5; i++) begin
      tick();
      chk_a("en_resume", 1, 0, 0, 18'(i));
    end
    tick();
    chk_a("en_expire", 0, 1, 1, 6);

    // Retrigger on the terminal edge suppresses the pulse.
    a.OP = 1'b1;
    tick();
    chk_a("ab_arm", 0, 0, 0, 0);
    a.Period = 18'd3; a.OP = 1'b0;
    tick(); chk_a("ab_start", 1, 0, 0, 0);
    tick(); chk_a("ab_c1", 1, 0, 0, 1);
    tick(); chk_a("ab_c2", 1, 0, 0, 2);
    a.OP = 1'b1;
    tick();
    chk_a("ab_abort", 0, 0, 0, 0);
    a.OP = 1'b0;
    tick();
    chk_a("ab_rerun", 1, 0, 0, 0);

    // Reset in the middle of a count.
    a.OP = 1'b1;
    tick();
    a.Period = 18'd10; a.OP = 1'b0;
    tick();
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk_a("rst_count", 1, 0, 0, 18'(i));
    end
    Rst_n = 1'b0;
    tick();
    chk_a("rst_mid", 0, 0, 0, 0);
    Rst_n = 1'b1;
    tick();
    chk_a("rst_after0", 0, 0, 0, 0);
    tick();
    chk_a("rst_after1", 0, 0, 0, 0);

    // Period=0 acts as 1; Mode 3 behaves like Mode 0.
    a.OP = 1'b1;
    tick();
    a.Period = 18'd0; a.Mode = 2'd3; a.OP = 1'b0;
    tick();
    chk_a("p0_start", 1, 0, 0, 0);
    tick();
    chk_a("p0_expire", 0, 1, 1, 1);
    tick();
    chk_a("p0_done", 0, 0, 1, 1);

    // WIDTH=4 with full-scale Period=15: no wrap.
    b.OP = 1'b1;
    tick();
    chk_b("w4_arm", 0, 0, 0, 0);
    b.Period = 4'd15; b.Mode = 2'd0; b.OP = 1'b0;
    tick();
    chk_b("w4_start", 1, 0, 0, 0);
    for (int i = 1; i <= 14; i++) begin
      tick();
      chk_b("w4_count", 1, 0, 0, 4'(i));
    end
    tick();
    chk_b("w4_expire", 0, 1, 1, 15);
    tick();
    chk_b("w4_done", 0, 0, 1, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pulso_timer.md
Name: pulso_timer

Overview:
- Parametrised, fully synchronous successor to the 18-stage ripple-counter pulse delay in the adder/7-segment project.
- Counts Clk cycles after the OP trigger is released.
- Signals expiry on Mo and Pulse. Mode selects latched one-shot, single-cycle one-shot or periodic operation.
- Terminal count is a run-time input rather than a hard-wired decode. An enable allows pausing.

Parameters:
- WIDTH, 18, counter and period width in bits.
- DEF_MODE, 0, reserved default for Mode when the port is tied off at integration (no RTL effect).

Ports:
- Clk  in  1  system clock; all state updates on its rising edge.
- Rst_n  in  1  synchronous active-low reset, sampled on the Clk rising edge.
- OP  in  1  trigger level: high = arm/clear, high→low = start.
- En  in  1  count enable; 0 freezes Count and state in RUN.
- Period  in  WIDTH  terminal count P; 0 treated as 1.
- Mode  in  2  0 = latched one-shot, 1 = single-cycle one-shot, 2 = periodic, 3 = same as 0.
- Mo  out  1  done level (mode 0/3).
- Pulse  out  1  one-cycle expiry strobe (all modes).
- Busy  out  1  high while in RUN.
- Count  out  WIDTH  current count.

Behaviour:
- Interface: one clock, Clk. Reset Rst_n is synchronous, active-low.
- Reset (Rst_n=0 at an edge): state=IDLE; Count=0; Mo=0; Pulse=0; Busy=0; latched period/mode=0. Rst_n has priority over all other inputs, including mid-count.
- States: IDLE, ARM, RUN, DONE. All outputs are registered.
- IDLE:
  - OP=1 → ARM.
  - OP low at reset release never starts a count; a fresh high→low is required.
- ARM:
  - Count=0, Mo=0.
  - OP=0 at an edge → RUN. At that same edge, Period (0→1) is captured as Preg and Mode as Mreg.
- RUN:
  - Each edge with En=1 increments Count.
  - Edge with En=1 and Count==Preg-1 is the terminal edge. With En held 1, Pulse rises exactly Preg edges after the ARM→RUN edge.
  - Terminal, Mreg 0/3: Count=Preg, Mo=1, Pulse=1 for one cycle, → DONE.
  - Terminal, Mreg 1: Pulse=1 for one cycle, Count=0, → IDLE.
  - Terminal, Mreg 2: Pulse=1 for one cycle, Count=0, Preg re-captured from Period (0→1), stay RUN. Mode is not re-sampled.
  - En=0: Count, state and Mo hold; Pulse=0.
- DONE: Mo held 1, Count held at Preg, Pulse=0.
- OP=1 in RUN or DONE (abort/retrigger): at that edge → ARM, Count=0, Mo=0, Pulse=0. This takes priority over a simultaneous terminal edge: no Pulse is emitted.
- Period and Mode changes during RUN are ignored, except the mode-2 re-capture at the terminal edge.
- Busy=1 exactly when state==RUN.
- Count never exceeds Preg ≤ 2^WIDTH-1, so no wrap-around.
- Preg=1: terminal on the first enabled RUN edge.

Test Plan:
- Reset release, then OP 1→0 with Period=5, Mode=0, En=1 → Busy for 5 cycles, Count 1..4; Pulse and Mo rise together after the 5th edge; Mo stays 1, Count=5; Pulse lasts 1 cycle.
- Period=3, Mode=2, En=1, OP released → Pulse every 3 cycles, Count 1,2,0,1,2,0. Period changed to 2 mid-run → next interval still 3, then intervals of 2.
- Period=4, Mode=1 → single Pulse at edge 4; state IDLE; Mo stays 0; no further pulses until OP toggles.
- Period=6, Mode=0; En=0 for 3 cycles after Count=2 → Count frozen at 2; Pulse arrives 3 cycles later than nominal (edge 9).
- OP raised at the terminal edge (Count=Preg-1) → no Pulse, Mo=0, Count=0, state ARM. Rst_n=0 mid-count with Count=7 → all outputs 0 next cycle; OP low afterwards does not start a count.
- Period=0 → behaves as 1: Pulse one edge after start. WIDTH=4, Period=15 → Count reaches 15 without wrap and Mo=1.
